latch_out_filter: RTL and testbench
===================================

LATCH_OUT_FILTER -- requirements
Module: latch_out_filter

Purpose: downstream stage of the d_latch. Synchronises the latch output q into the clk domain, debounces it, emits edge pulses and counts stable toggles.

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth (legal range 2..4).
REQ-002 The module SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive equal synchronised samples required to accept a level (legal range 2..255).
REQ-003 The module SHALL have parameter CNT_W, default 8, giving the toggle counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 d_in  input  1  asynchronous level, driven by the d_latch q output.
REQ-007 clr_cnt  input  1  synchronous clear of toggle_cnt.
REQ-008 q_sync  output  1  last synchroniser stage.
REQ-009 q_stable  output  1  debounced level.
REQ-010 rise_pulse  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-011 fall_pulse  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-012 toggle_cnt  output  CNT_W  count of accepted changes.
REQ-013 cnt_sat  output  1  high while toggle_cnt equals all-ones.

Function
REQ-014 Synchroniser: d_in SHALL pass through SYNC_STAGES flops, and q_sync SHALL be the last stage.
REQ-015 FSM states SHALL be STABLE_LO, PEND_HI, STABLE_HI and PEND_LO, with a run counter run_cnt of 8 bits.
REQ-016 STABLE_LO SHALL go to PEND_HI with run_cnt=1 when q_sync=1, and SHALL otherwise hold.
REQ-017 PEND_HI SHALL return to STABLE_LO when q_sync=0 (glitch rejected, no pulse, no count).
REQ-018 PEND_HI SHALL go to STABLE_HI when q_sync=1 and run_cnt=STABLE_CYCLES-1, and SHALL otherwise increment run_cnt.
REQ-019 STABLE_HI and PEND_LO SHALL behave as the mirror of REQ-016..018 with the q_sync polarity inverted.
REQ-020 Latency: with d_in held at 1 from the first rising edge that samples it, q_stable SHALL become 1 after edge SYNC_STAGES+STABLE_CYCLES, counting that edge as edge 1 (edge 6 at defaults); falling latency SHALL be the same.
REQ-021 q_stable SHALL be 1 in STABLE_HI and PEND_LO, and 0 otherwise.
REQ-022 rise_pulse SHALL be high for exactly the one cycle in which q_stable first reads 1 after PEND_HI->STABLE_HI; fall_pulse SHALL do the same for PEND_LO->STABLE_LO.
REQ-023 rise_pulse and fall_pulse SHALL never be high in the same cycle.
REQ-024 toggle_cnt SHALL increment by 1 at the edge that produces either pulse, and SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-025 clr_cnt=1 SHALL set toggle_cnt to 0 at the next edge; clear SHALL win over a simultaneous increment.
REQ-026 Toggling d_in faster than STABLE_CYCLES cycles SHALL leave q_stable, both pulses and toggle_cnt unchanged.

Reset
REQ-027 While reset=1, all synchroniser flops, q_sync, q_stable, rise_pulse, fall_pulse, toggle_cnt, cnt_sat and run_cnt SHALL be 0, and the state SHALL be STABLE_LO.
REQ-028 Reset asserted mid-PEND_HI SHALL abandon the pending change with no pulse; after release the block SHALL behave as from power-up.

Structure
REQ-029 The FSM state encoding and default parameter constants SHALL live in the shared package latch_filter_pkg.
REQ-030 The synchroniser SHALL be the sub-module sync_chain (parameter SYNC_STAGES, ports clk, reset, d, q); the FSM and counter SHALL stay in the top.

Verification
REQ-031 Test 1: reset=1 for 2 cycles, then released with d_in=0 -> all outputs 0 and state STABLE_LO.
REQ-032 Test 2: defaults, d_in 0->1 held -> q_stable=1 and rise_pulse high for one cycle after edge 6, toggle_cnt=1.
REQ-033 Test 3: d_in high for 3 cycles, then low -> q_sync pulses, q_stable stays 0, no pulse, toggle_cnt=0.
REQ-034 Test 4: CNT_W=2 with 5 accepted toggles -> toggle_cnt stops at 3 and cnt_sat=1; clr_cnt then gives toggle_cnt=0 and cnt_sat=0.
REQ-035 Test 5: clr_cnt asserted in the same cycle as rise_pulse -> toggle_cnt=0 on the next edge.
REQ-036 Test 6: reset asserted 2 cycles into PEND_HI and released with d_in=1 -> no pulse during reset; the full 6-edge latency restarts after release.

Source files
------------

// File: rtl/latch_filter_pkg.sv
// Shared constants and FSM state encoding for the latch output filter.
package latch_filter_pkg;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned RUN_W             = 8;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } filt_state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stages <= '0;
    else       stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/latch_out_filter.sv
// Synchronises and debounces the d_latch output, emitting edge pulses and
// a saturating count of accepted level changes.
module latch_out_filter
  import latch_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_in,
  input  logic             clr_cnt,
  output logic             q_sync,
  output logic             q_stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat
);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  filt_state_e      state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_nxt, fall_nxt;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_in),
    .q     (q_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STABLE_LO;
      run_cnt    <= '0;
      q_stable   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      toggle_cnt <= '0;
      cnt_sat    <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      q_stable   <= (state_nxt == STABLE_HI) || (state_nxt == PEND_LO);
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      toggle_cnt <= cnt_nxt;
      cnt_sat    <= (cnt_nxt == CNT_MAX);
    end
  end

  // A new level is accepted only after STABLE_CYCLES consecutive matching samples.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    cnt_nxt   = toggle_cnt;

    case (state)
      STABLE_LO: begin
        if (q_sync) begin
          state_nxt = PEND_HI;
          run_nxt   = RUN_W'(1);
        end else begin
          run_nxt   = '0;
        end
      end
      PEND_HI: begin
        if (!q_sync) begin
          state_nxt = STABLE_LO;
          run_nxt   = '0;
        end else if (run_cnt == RUN_LAST) begin
          state_nxt = STABLE_HI;
          run_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          run_nxt   = run_cnt + RUN_W'(1);
        end
      end
      STABLE_HI: begin
        if (!q_sync) begin
          state_nxt = PEND_LO;
          run_nxt   = RUN_W'(1);
        end else begin
          run_nxt   = '0;
        end
      end
      PEND_LO: begin
        if (q_sync) begin
          state_nxt = STABLE_HI;
          run_nxt   = '0;
        end else if (run_cnt == RUN_LAST) begin
          state_nxt = STABLE_LO;
          run_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          run_nxt   = run_cnt + RUN_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        run_nxt   = '0;
      end
    endcase

    // Clear has priority over an increment on the same edge.
    if (clr_cnt) begin
      cnt_nxt = '0;
    end else if ((rise_nxt || fall_nxt) && (toggle_cnt != CNT_MAX)) begin
      cnt_nxt = toggle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_latch_out_filter.sv
// Randomised and directed bench for latch_out_filter, checked against a
// sample-window reference model (default instance plus a CNT_W=2 instance).
module tb_latch_out_filter;

  localparam int SYNC = 2;
  localparam int N    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_in = 1'b0;
  logic       clr_cnt = 1'b0;

  logic       q_sync_a, q_stable_a, rise_a, fall_a, sat_a;
  logic [7:0] cnt_a;
  logic       q_sync_b, q_stable_b, rise_b, fall_b, sat_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SYNC-1:0] m_pipe = '0;
  logic            win[$];
  logic            m_stable = 1'b0;
  logic            m_rise = 1'b0;
  logic            m_fall = 1'b0;
  int              m_cnt8 = 0;
  int              m_cnt2 = 0;

  always #5 clk = ~clk;

  latch_out_filter u_dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .clr_cnt    (clr_cnt),
    .q_sync     (q_sync_a),
    .q_stable   (q_stable_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .toggle_cnt (cnt_a),
    .cnt_sat    (sat_a)
  );

  latch_out_filter #(.CNT_W(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .clr_cnt    (clr_cnt),
    .q_sync     (q_sync_b),
    .q_stable   (q_stable_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .toggle_cnt (cnt_b),
    .cnt_sat    (sat_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // One clock edge of the behavioural model: a level is accepted once the
  // last N samples seen after the synchroniser all differ from the current level.
  task automatic model_edge(input logic d, input logic c, input logic r);
    logic seen;
    logic acc;
    if (r) begin
      m_pipe = '0;
      win.delete();
      m_stable = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_cnt8 = 0;
      m_cnt2 = 0;
      return;
    end
    seen = m_pipe[SYNC-1];
    m_pipe = {m_pipe[SYNC-2:0], d};
    win.push_back(seen);
    if (win.size() > N) void'(win.pop_front());
    acc = (win.size() == N);
    foreach (win[i]) if (win[i] == m_stable) acc = 1'b0;
    m_rise = acc && !m_stable;
    m_fall = acc && m_stable;
    if (acc) m_stable = !m_stable;
    if (c) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (acc) begin
      m_cnt8 = (m_cnt8 == 255) ? 255 : m_cnt8 + 1;
      m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
    end
  endtask

  task automatic compare_all();
    check("q_sync",     32'(q_sync_a),   32'(m_pipe[SYNC-1]));
    check("q_stable",   32'(q_stable_a), 32'(m_stable));
    check("rise",       32'(rise_a),     32'(m_rise));
    check("fall",       32'(fall_a),     32'(m_fall));
    check("cnt8",       32'(cnt_a),      32'(m_cnt8));
    check("sat8",       32'(sat_a),      32'(m_cnt8 == 255));
    check("q_stable_b", 32'(q_stable_b), 32'(m_stable));
    check("cnt2",       32'(cnt_b),      32'(m_cnt2));
    check("sat2",       32'(sat_b),      32'(m_cnt2 == 3));
    check("pulse_excl", 32'(rise_a && fall_a), 32'(0));
  endtask

  task automatic step(input logic d, input logic c, input logic r);
    @(negedge clk);
    d_in = d;
    clr_cnt = c;
    reset = r;
    @(posedge clk);
    model_edge(d, c, r);
    #1;
    compare_all();
  endtask

  initial begin
    int lat;
    int seen_pulse;

    // Test 1: reset for two cycles, release with d_in low
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("t1_q_stable", 32'(q_stable_a), 32'(0));
    check("t1_cnt", 32'(cnt_a), 32'(0));

    // Test 2: rising latency SYNC+N edges, one count
    lat = 0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      step(1, 0, 0);
      if (q_stable_a) begin
        lat = e;
        check("t2_rise_with_stable", 32'(rise_a), 32'(1));
      end
    end
    check("t2_latency", 32'(lat), 32'(6));
    step(1, 0, 0);
    check("t2_rise_one_cycle", 32'(rise_a), 32'(0));
    check("t2_cnt", 32'(cnt_a), 32'(1));

    // Test 3: three-cycle glitch rejected
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    seen_pulse = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      if (q_stable_a || rise_a || fall_a) seen_pulse = 1;
    end
    check("t3_no_accept", 32'(seen_pulse), 32'(0));
    check("t3_cnt", 32'(cnt_a), 32'(0));

    // Test 4: saturation of the 2-bit counter, then clear
    step(0, 1, 0);
    for (int t = 0; t < 5; t++)
      for (int i = 0; i < 8; i++) step((t % 2 == 0) ? 1'b1 : 1'b0, 0, 0);
    check("t4_cnt2_sat_val", 32'(cnt_b), 32'(3));
    check("t4_sat2", 32'(sat_b), 32'(1));
    check("t4_cnt8", 32'(cnt_a), 32'(5));
    step(1, 1, 0);
    check("t4_cnt2_clr", 32'(cnt_b), 32'(0));
    check("t4_sat2_clr", 32'(sat_b), 32'(0));

    // Test 5: clear in the same cycle as rise_pulse
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    seen_pulse = 0;
    for (int i = 0; i < 20 && seen_pulse == 0; i++) begin
      step(1, 0, 0);
      if (rise_a) seen_pulse = 1;
    end
    check("t5_rise_seen", 32'(seen_pulse), 32'(1));
    step(1, 1, 0);
    check("t5_cnt_cleared", 32'(cnt_a), 32'(0));

    // Test 6: reset two cycles into PEND_HI restarts the full latency
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    seen_pulse = 0;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1);
      if (rise_a || q_stable_a) seen_pulse = 1;
    end
    check("t6_no_pulse_in_reset", 32'(seen_pulse), 32'(0));
    lat = 0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      step(1, 0, 0);
      if (q_stable_a) lat = e;
    end
    check("t6_latency", 32'(lat), 32'(6));

    // Randomised runs of held levels with occasional clears and resets
    for (int r = 0; r < 600; r++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        step(lvl, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
